// File: rtl/kd_tree_pkg.sv
// Shared KD-tree constants, the loader state type and node-record field helpers.
// A node record holds the median in its high bits and the split-dimension index in its low bits.
package kd_tree_pkg;

  localparam int STORAGE_WIDTH = 22;
  localparam int IDX_WIDTH     = 11;
  localparam int MEDIAN_WIDTH  = STORAGE_WIDTH - IDX_WIDTH;
  localparam int NUM_NODES     = 31;
  localparam int NUM_DIMS      = 5;
  localparam int CNT_WIDTH     = $clog2(NUM_NODES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

  function automatic logic [MEDIAN_WIDTH-1:0] get_median(input logic [STORAGE_WIDTH-1:0] rec);
    return rec[STORAGE_WIDTH-1:IDX_WIDTH];
  endfunction

  function automatic logic [IDX_WIDTH-1:0] get_idx(input logic [STORAGE_WIDTH-1:0] rec);
    return rec[IDX_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/kd_node_wen_decoder.sv
// Turns the current node slot into a one-hot write-enable vector for the internal_node array.
module kd_node_wen_decoder
  import kd_tree_pkg::*;
(
  input  logic [CNT_WIDTH-1:0] i_node_cnt,
  input  logic                 i_en,
  output logic [NUM_NODES-1:0] o_wen
);

  always_comb begin
    for (int i = 0; i < NUM_NODES; i++) begin
      o_wen[i] = i_en && (i_node_cnt == CNT_WIDTH'(i));
    end
  end

endmodule

// File: rtl/kd_node_loader.sv
// Streams node records into the KD-tree internal nodes in breadth-first order (node 0 = root).
// Optional KD_LOADER_IDX_CHECK_EN: records with an out-of-range dim index skip their slot and set err.
module kd_node_loader
  import kd_tree_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [STORAGE_WIDTH-1:0] in_data,
  output logic [NUM_NODES-1:0]     node_wen,
  output logic [STORAGE_WIDTH-1:0] node_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  loader_state_t              r_state;
  loader_state_t              w_next_state;
  logic [CNT_WIDTH-1:0]       r_node_cnt;
  logic [NUM_NODES-1:0]       r_node_wen;
  logic [NUM_NODES-1:0]       w_wen_dec;
  logic [STORAGE_WIDTH-1:0]   r_node_wdata;
  logic                       w_handshake;
  logic                       w_last;
  logic                       w_rec_ok;

  assign w_handshake = in_valid && in_ready;
  assign w_last      = (r_node_cnt == CNT_WIDTH'(NUM_NODES - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = LOAD;
      LOAD: begin
        if (start)                      w_next_state = LOAD;
        else if (w_handshake && w_last) w_next_state = DONE;
      end
      DONE:    if (start) w_next_state = LOAD;
      default: w_next_state = IDLE;
    endcase
  end

  // start wins over a same-cycle record: the record stays with the sender.
  always_comb begin
    in_ready = (r_state == LOAD) && !start;
    busy     = (r_state == LOAD);
    done     = (r_state == DONE);
  end

`ifdef KD_LOADER_IDX_CHECK_EN
  logic r_err;

  assign w_rec_ok = (get_idx(in_data) < IDX_WIDTH'(NUM_DIMS));

  always_ff @(posedge clk) begin
    if (rst || start) begin
      r_err <= 1'b0;
    end else if (w_handshake && !w_rec_ok) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_rec_ok = 1'b1;
  assign err      = 1'b0;
`endif

  kd_node_wen_decoder u_wen_decoder (
    .i_node_cnt (r_node_cnt),
    .i_en       (w_handshake && w_rec_ok),
    .o_wen      (w_wen_dec)
  );

  // The wen pulse trails its handshake by one cycle; reset in that cycle drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_node_cnt   <= '0;
      r_node_wen   <= '0;
      r_node_wdata <= '0;
    end else begin
      r_node_wen <= w_wen_dec;
      if (start) begin
        r_node_cnt <= '0;
      end else if (w_handshake) begin
        r_node_cnt <= r_node_cnt + 1'b1;
      end
      if (w_handshake) begin
        r_node_wdata <= in_data;
      end
    end
  end

  assign node_wen   = r_node_wen;
  assign node_wdata = r_node_wdata;

endmodule
